// File: rtl/if_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_pkg
// Shared processor constants and types for the instruction fetch stage.
//   PC_W / INSTR_W    : program counter and instruction widths
//   RESET_PC_DEFAULT  : default first fetch address after reset
//   NOP_INSTR         : encoding presented when no instruction is valid
//   fetch_entry_t     : one fetch-queue entry (PC + instruction word)
//   word_align()      : clears the two byte-offset bits of an address
// -----------------------------------------------------------------------------
package if_fetch_unit_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  localparam logic [PC_W-1:0]    RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0013;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
    return addr & ~PC_W'(3);
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_if
// Instruction-memory request/response bus.
//   imem_req    : fetch request valid            (master -> slave)
//   imem_addr   : word-aligned fetch address     (master -> slave)
//   imem_gnt    : request accepted this cycle    (slave  -> master)
//   imem_rvalid : in-order response valid        (slave  -> master)
//   imem_rdata  : instruction word               (slave  -> master)
// -----------------------------------------------------------------------------
interface if_fetch_unit_if;
  import if_fetch_unit_pkg::*;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Power-of-two FIFO of fetched (PC, instruction) pairs.
//   clk, reset  : clock, synchronous active-high reset
//   flush_i     : discard all entries (wins over push/pop)
//   push_i      : write push_data_i at the tail
//   pop_i       : retire the head entry
//   head_o      : head entry (meaningful only while count_o != 0)
//   count_o     : number of valid entries
// -----------------------------------------------------------------------------
module fetch_queue
  import if_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  fetch_entry_t           push_data_i,
  input  logic                   pop_i,
  output fetch_entry_t           head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && !flush_i && (count_q != '0);
  // A full queue can still accept a push when the head leaves the same cycle.
  assign do_push = push_i && !flush_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: the storage array is deliberately not reset; count_q alone decides
  // validity, and leaving the array out of reset lets it map to plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction fetch stage: issues sequential word fetches, queues in-order
// responses, presents the oldest one to ID, and handles EX redirects by
// flushing the queue and discarding responses still in flight.
//   clk, reset      : clock, synchronous active-high reset
//   imem            : instruction-memory bus (master side)
//   redirect_valid  : taken branch/jump from EX (wins over stall and pop)
//   redirect_pc     : redirect target (byte offset bits ignored)
//   stall           : ID cannot accept this cycle
//   if_valid        : IF_PC / IF_Instr hold a valid instruction
//   IF_PC, IF_Instr : presented instruction (0 / NOP when not valid)
// -----------------------------------------------------------------------------
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              QDEPTH   = 2
) (
  input  logic                clk,
  input  logic                reset,
  if_fetch_unit_if.master     imem,
  input  logic                redirect_valid,
  input  logic [PC_W-1:0]     redirect_pc,
  input  logic                stall,
  output logic                if_valid,
  output logic [PC_W-1:0]     IF_PC,
  output logic [INSTR_W-1:0]  IF_Instr
);

  localparam int CNT_W  = $clog2(QDEPTH) + 1;
  localparam int OCC_W  = CNT_W + 1;
  // Headroom for several back-to-back redirects before old responses return.
  localparam int DROP_W = CNT_W + 4;

  logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;   // next address to request
  logic [PC_W-1:0]   rsp_pc_q,   rsp_pc_d;     // PC of oldest live response
  logic [CNT_W-1:0]  out_q,      out_d;        // live (enqueueable) in flight
  logic [DROP_W-1:0] drop_q,     drop_d;       // stale responses to discard

  logic [CNT_W-1:0]  q_count;
  fetch_entry_t      q_head;
  fetch_entry_t      push_entry;
  logic              push;
  logic              pop;
  logic              grant;
  logic [OCC_W-1:0]  occupancy;

  // Handshake and presentation.
  always_comb begin
    // NOTE: every output of a combinational block is assigned on all paths
    // (defaults first where branches exist) so no latch is inferred.
    if_valid  = (q_count != '0);
    pop       = if_valid && !stall && !redirect_valid;
    // Credit the slot the head frees this cycle so a 1-cycle memory streams
    // one instruction per cycle; under stall this reduces to count+outstanding.
    occupancy = OCC_W'(q_count) + OCC_W'(out_q) - OCC_W'(pop);

    imem.imem_req  = !reset && !redirect_valid && (occupancy < OCC_W'(QDEPTH));
    imem.imem_addr = fetch_pc_q;
    grant          = imem.imem_req && imem.imem_gnt;

    IF_PC    = if_valid ? q_head.pc    : '0;
    IF_Instr = if_valid ? q_head.instr : NOP_INSTR;
  end

  // Request/response bookkeeping. Stale responses are always older than live
  // ones (responses are in order), so drops are consumed first.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    out_d      = out_q;
    drop_d     = drop_q;
    push       = 1'b0;

    if (imem.imem_rvalid) begin
      if (drop_q != '0) begin
        drop_d = drop_q - DROP_W'(1);
      end else if (out_q != '0) begin
        out_d    = out_q - CNT_W'(1);
        push     = !redirect_valid;
        rsp_pc_d = rsp_pc_q + PC_W'(4);
      end
    end

    if (grant) begin
      out_d      = out_d + CNT_W'(1);
      fetch_pc_d = fetch_pc_q + PC_W'(4);
    end

    // Everything still live becomes stale; a response landing this very
    // cycle was already removed from out_d above and is not pushed.
    if (redirect_valid) begin
      drop_d     = drop_d + DROP_W'(out_d);
      out_d      = '0;
      fetch_pc_d = word_align(redirect_pc);
      rsp_pc_d   = word_align(redirect_pc);
    end
  end

  assign push_entry = '{pc: rsp_pc_q, instr: imem.imem_rdata};

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_fetch_queue (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (q_head),
    .count_o     (q_count)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit
// Directed bench for if_fetch_unit with an in-order memory model of
// programmable latency. Every granted address is pushed to a scoreboard and
// popped when ID consumes an instruction; redirects and resets clear it.
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_rsp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] IF_PC;
  logic [31:0] IF_Instr;

  if_fetch_unit_if imem_bus ();

  if_fetch_unit #(
    .RESET_PC (RESET_PC),
    .QDEPTH   (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem           (imem_bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .if_valid       (if_valid),
    .IF_PC          (IF_PC),
    .IF_Instr       (IF_Instr)
  );

  int          errors  = 0;
  int          checks  = 0;
  int          cyc     = 0;
  int          mem_lat = 1;
  bit          spurious = 1'b0;
  int          first_gnt;
  logic [31:0] exp_fetch_pc;
  logic [31:0] held;
  mem_rsp_t    pend[$];
  exp_t        sb[$];
  logic [31:0] pop_log[$];
  int          pop_cyc[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  function automatic logic [31:0] log_at(input int i);
    if (i < pop_log.size()) return pop_log[i];
    return 32'hDEAD_DEAD;
  endfunction

  function automatic int cyc_at(input int i);
    if (i < pop_cyc.size()) return pop_cyc[i];
    return -1000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive the memory response, sample the DUT mid-cycle,
  // update the scoreboard, then advance to 1 time unit after the next edge.
  task automatic step();
    mem_rsp_t r;
    exp_t     e;
    if (spurious) begin
      imem_bus.imem_rvalid = 1'b1;
      imem_bus.imem_rdata  = 32'hBAD0_BAD0;
      spurious = 1'b0;
    end else if (pend.size() != 0 && pend[0].due <= cyc) begin
      r = pend.pop_front();
      imem_bus.imem_rvalid = 1'b1;
      imem_bus.imem_rdata  = instr_of(r.addr);
    end else begin
      imem_bus.imem_rvalid = 1'b0;
      imem_bus.imem_rdata  = 32'h0;
    end
    #1;
    if (reset || redirect_valid) check("req_blocked", {31'b0, imem_bus.imem_req}, 32'd0);
    if (imem_bus.imem_req && imem_bus.imem_gnt) begin
      check("fetch_addr", imem_bus.imem_addr, exp_fetch_pc);
      r.addr = imem_bus.imem_addr;
      r.due  = cyc + mem_lat;
      pend.push_back(r);
      e.pc    = imem_bus.imem_addr;
      e.instr = instr_of(imem_bus.imem_addr);
      sb.push_back(e);
      exp_fetch_pc = exp_fetch_pc + 32'd4;
      if (first_gnt < 0) first_gnt = cyc;
    end
    if (!reset && !redirect_valid && if_valid && !stall) begin
      if (sb.size() == 0) begin
        check("pop_unexpected", {31'b0, if_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("if_pc", IF_PC, e.pc);
        check("if_instr", IF_Instr, e.instr);
        pop_log.push_back(IF_PC);
        pop_cyc.push_back(cyc);
      end
    end
    if (reset) begin
      sb.delete();
      exp_fetch_pc = RESET_PC;
    end else if (redirect_valid) begin
      sb.delete();
      exp_fetch_pc = redirect_pc & ~32'h3;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_until(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && pop_log.size() < n; i++) step();
    check(tag, 32'(pop_log.size()), 32'(n));
  endtask

  initial begin
    reset                 = 1'b1;
    stall                 = 1'b0;
    redirect_valid        = 1'b0;
    redirect_pc           = 32'h0;
    imem_bus.imem_gnt     = 1'b1;
    imem_bus.imem_rvalid  = 1'b0;
    imem_bus.imem_rdata   = 32'h0;
    exp_fetch_pc          = RESET_PC;
    first_gnt             = -1;

    // Reset state.
    @(posedge clk);
    #1;
    check("rst_valid", {31'b0, if_valid}, 32'd0);
    check("rst_pc", IF_PC, 32'h0);
    check("rst_instr", IF_Instr, NOP);
    step();

    // Streaming from reset with a 1-cycle memory: 0,4,8,C back to back.
    reset = 1'b0;
    first_gnt = -1;
    pop_log.delete();
    pop_cyc.delete();
    run_until(4, 20, "seq_count");
    check("seq_pc0", log_at(0), 32'h0);
    check("seq_pc1", log_at(1), 32'h4);
    check("seq_pc2", log_at(2), 32'h8);
    check("seq_pc3", log_at(3), 32'hC);
    check("first_latency", 32'(cyc_at(0) - first_gnt), 32'd2);
    check("back_to_back", 32'(cyc_at(3) - cyc_at(0)), 32'd3);

    // Stall for 3 cycles while PC 8 is presented.
    reset = 1'b1;
    step();
    reset = 1'b0;
    pop_log.delete();
    run_until(2, 20, "pre_stall");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_valid", {31'b0, if_valid}, 32'd1);
      check("stall_pc", IF_PC, 32'h8);
      check("stall_instr", IF_Instr, instr_of(32'h8));
      check("stall_req", {31'b0, imem_bus.imem_req}, 32'd0);
      step();
    end
    stall = 1'b0;
    pop_log.delete();
    run_until(2, 10, "post_stall");
    check("resume_pc0", log_at(0), 32'h8);
    check("resume_pc1", log_at(1), 32'hC);

    // Redirect with two requests outstanding (3-cycle memory).
    reset = 1'b1;
    step();
    reset = 1'b0;
    mem_lat = 3;
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    step();
    redirect_valid = 1'b0;
    #1;
    check("redir_addr", imem_bus.imem_addr, 32'h0000_0100);
    check("redir_flush", {31'b0, if_valid}, 32'd0);
    pop_log.delete();
    run_until(2, 20, "redir_pops");
    check("redir_pc0", log_at(0), 32'h0000_0100);

    // Second redirect while drops are pending; unaligned final target.
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    step();
    redirect_valid = 1'b0;
    #1;
    check("align_addr", imem_bus.imem_addr, 32'h0000_0100);
    check("align_flush", {31'b0, if_valid}, 32'd0);
    pop_log.delete();
    run_until(2, 30, "dbl_pops");
    check("dbl_pc0", log_at(0), 32'h0000_0100);
    check("dbl_pc1", log_at(1), 32'h0000_0104);

    // Grant withheld for 5 cycles, then a response with nothing outstanding.
    mem_lat = 1;
    pop_log.delete();
    run_until(2, 20, "pre_gnt0");
    imem_bus.imem_gnt = 1'b0;
    #1;
    held = imem_bus.imem_addr;
    for (int i = 0; i < 5; i++) begin
      step();
      check("gnt0_addr", imem_bus.imem_addr, held);
    end
    check("gnt0_drained", {31'b0, if_valid}, 32'd0);
    check("gnt0_req", {31'b0, imem_bus.imem_req}, 32'd1);
    spurious = 1'b1;
    step();
    check("spurious_ignored", {31'b0, if_valid}, 32'd0);
    imem_bus.imem_gnt = 1'b1;
    pop_log.delete();
    run_until(2, 10, "gnt1_pops");
    check("gnt_resume0", log_at(0), held);
    check("gnt_resume1", log_at(1), held + 32'd4);

    // Address wrap at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    check("wrap_addr0", imem_bus.imem_addr, 32'hFFFF_FFFC);
    pop_log.delete();
    step();
    check("wrap_addr1", imem_bus.imem_addr, 32'h0000_0000);
    run_until(2, 10, "wrap_pops");
    check("wrap_pc0", log_at(0), 32'hFFFF_FFFC);
    check("wrap_pc1", log_at(1), 32'h0000_0000);

    // Reset mid-stream: in-flight work abandoned, restart from RESET_PC.
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_valid", {31'b0, if_valid}, 32'd0);
    check("mid_rst_pc", IF_PC, 32'h0);
    check("mid_rst_instr", IF_Instr, NOP);
    pop_log.delete();
    run_until(1, 10, "post_rst_pops");
    check("post_rst_pc", log_at(0), RESET_PC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter QDEPTH, default 2: fetch-queue entries (power of two, 2..4).
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port imem_req, output, 1: fetch request valid.
REQ-006 SHALL have port imem_addr, output, 32: word-aligned fetch address.
REQ-007 SHALL have port imem_gnt, input, 1: request accepted this cycle when imem_req && imem_gnt.
REQ-008 SHALL have port imem_rvalid, input, 1: response valid; responses return in order, at least 1 cycle after grant.
REQ-009 SHALL have port imem_rdata, input, 32: instruction word.
REQ-010 SHALL have port redirect_valid, input, 1: taken branch/jump from EX.
REQ-011 SHALL have port redirect_pc, input, 32: redirect target.
REQ-012 SHALL have port stall, input, 1: ID cannot accept this cycle.
REQ-013 SHALL have port if_valid, output, 1: IF_PC/IF_Instr hold a valid instruction.
REQ-014 SHALL have port IF_PC, output, 32: PC of the presented instruction.
REQ-015 SHALL have port IF_Instr, output, 32: presented instruction word.

Function
REQ-016 SHALL keep fetch_pc; on each grant, fetch_pc <= fetch_pc + 4 (mod 2^32, wraps FFFF_FFFC -> 0000_0000).
REQ-017 SHALL drive imem_addr = fetch_pc and imem_req = 1 only when (queue count + outstanding) < QDEPTH and no redirect in the same cycle.
REQ-018 SHALL store each accepted response (PC, instr) in a FIFO; the entry becomes visible the cycle after imem_rvalid.
REQ-019 SHALL present the FIFO head: if_valid = (count != 0); IF_PC/IF_Instr = head fields; values hold stable while stall = 1.
REQ-020 SHALL pop the head when if_valid && !stall.
REQ-021 SHALL support a simultaneous push and pop in one cycle, count unchanged; push into a full queue SHALL be impossible by REQ-017.
REQ-022 On redirect_valid: next cycle fetch_pc = {redirect_pc[31:2],2'b00}, queue empty, if_valid = 0; a grant in the redirect cycle SHALL be suppressed.
REQ-023 Responses for requests granted before a redirect SHALL be discarded via a drop counter (set to outstanding count at redirect, decremented per imem_rvalid), never enqueued.
REQ-024 A second redirect while drops are pending SHALL add the then-outstanding count; the latest redirect target wins.
REQ-025 redirect_valid SHALL take priority over stall and pop in the same cycle.
REQ-026 imem_rvalid with nothing outstanding SHALL be ignored.
REQ-027 Best-case latency: request at cycle t, rvalid at t+1, if_valid at t+2; sustained throughput one instruction per cycle with 1-cycle memory.

Reset
REQ-028 When reset = 1 at a clock edge: fetch_pc = RESET_PC, queue count = 0, outstanding = 0, drop = 0.
REQ-029 During and after reset: imem_req = 0 in the reset cycle, if_valid = 0, IF_PC = 0, IF_Instr = 32'h0000_0013 (NOP).
REQ-030 Reset mid-operation SHALL abandon in-flight requests; their late responses SHALL be ignored per REQ-026.

Structure
REQ-031 SHALL take RESET_PC default, NOP encoding (32'h0000_0013) and PC-width constant from the shared processor package.
REQ-032 SHALL instantiate one sub-module, fetch_queue (parameterised FIFO with push/pop/flush, count output).

Verification
REQ-033 Reset release, 1-cycle memory, no stall -> IF_PC sequence 0,4,8,C on consecutive cycles starting 2 cycles after first request.
REQ-034 stall = 1 for 3 cycles with IF_PC = 8 -> IF_PC/IF_Instr held at 8; imem_req drops once queue+outstanding = 2; resumes at C with no loss.
REQ-035 redirect_pc = 0000_0100 while 2 requests outstanding -> both responses dropped; next valid IF_PC = 100.
REQ-036 redirect_pc = 0000_0102 -> fetch address 0000_0100.
REQ-037 imem_gnt held 0 for 5 cycles -> imem_addr stable, if_valid falls after queue drains, no duplicate PCs.
REQ-038 fetch_pc = FFFF_FFFC granted -> next imem_addr = 0000_0000.
